// File: rtl/nes_bus_pkg.sv
// Shared constants and enums for the NES CPU-side bus controller.
package nes_bus_pkg;

  localparam logic [15:0] RAM_BASE = 16'h0000;
  localparam logic [15:0] PPU_BASE = 16'h2000;
  localparam logic [15:0] IO_BASE  = 16'h4000;
  localparam logic [15:0] PRG_BASE = 16'h4020;
  localparam logic [15:0] DMA_REG  = 16'h4014;

  typedef enum logic [2:0] {
    DMA_IDLE,
    DMA_HALT,
    DMA_ALIGN,
    DMA_RD,
    DMA_WR
  } dma_state_t;

  typedef enum logic [2:0] {
    REG_RAM,
    REG_PPU,
    REG_IO,
    REG_PRG,
    REG_NONE
  } bus_region_t;

endpackage

// File: rtl/cpu_bus_ctrl_if.sv
// CPU-side bus bundle: CPU request/response plus the slave strobes and data.
interface cpu_bus_ctrl_if #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned RAM_AW     = 11,
  parameter int unsigned PPU_REG_AW = 3
);
  logic                  CPU_CE;
  logic [ADDR_W-1:0]     CPU_ADDR;
  logic [DATA_W-1:0]     CPU_DATA_OUT;
  logic                  CPU_RW_n;
  logic [DATA_W-1:0]     CPU_DATA_IN;
  logic                  CPU_RDY;
  logic [ADDR_W-1:0]     BUS_ADDR;
  logic [DATA_W-1:0]     BUS_DATA;
  logic                  BUS_RW_n;
  logic [RAM_AW-1:0]     RAM_ADDR;
  logic                  RAM_wren;
  logic                  RAM_rden;
  logic [DATA_W-1:0]     RAM_DATA;
  logic [PPU_REG_AW-1:0] PPU_REG;
  logic                  PPU_wren;
  logic                  PPU_rden;
  logic [DATA_W-1:0]     PPU_DATA;
  logic                  IO_wren;
  logic                  IO_rden;
  logic [DATA_W-1:0]     IO_DATA;
  logic                  IO_DATA_VALID;
  logic                  PRG_rden;
  logic                  PRG_wren;
  logic [DATA_W-1:0]     PRG_DATA;
  logic                  DMA_ACTIVE;

  // Controller side
  modport slave (
    input  CPU_CE, CPU_ADDR, CPU_DATA_OUT, CPU_RW_n,
    input  RAM_DATA, PPU_DATA, IO_DATA, IO_DATA_VALID, PRG_DATA,
    output CPU_DATA_IN, CPU_RDY, BUS_ADDR, BUS_DATA, BUS_RW_n,
    output RAM_ADDR, RAM_wren, RAM_rden, PPU_REG, PPU_wren, PPU_rden,
    output IO_wren, IO_rden, PRG_rden, PRG_wren, DMA_ACTIVE
  );

  // CPU core and slave side
  modport master (
    output CPU_CE, CPU_ADDR, CPU_DATA_OUT, CPU_RW_n,
    output RAM_DATA, PPU_DATA, IO_DATA, IO_DATA_VALID, PRG_DATA,
    input  CPU_DATA_IN, CPU_RDY, BUS_ADDR, BUS_DATA, BUS_RW_n,
    input  RAM_ADDR, RAM_wren, RAM_rden, PPU_REG, PPU_wren, PPU_rden,
    input  IO_wren, IO_rden, PRG_rden, PRG_wren, DMA_ACTIVE
  );
endinterface

// File: rtl/oam_dma_engine.sv
// $4014 OAM DMA: stalls the CPU and copies one page into the PPU OAM data port.
module oam_dma_engine #(
  parameter int unsigned          ADDR_W       = 16,
  parameter int unsigned          DATA_W       = 8,
  parameter int unsigned          PPU_REG_AW   = 3,
  parameter int unsigned          DMA_LEN      = 256,
  parameter logic [ADDR_W-1:0]    DMA_REG      = ADDR_W'(16'h4014),
  parameter logic [PPU_REG_AW-1:0] OAM_DATA_REG = PPU_REG_AW'(4)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce_i,
  input  logic              parity_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_data_i,
  input  logic              cpu_rw_n_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic [ADDR_W-1:0] bus_addr_c_o,
  output logic [DATA_W-1:0] bus_data_c_o,
  output logic              bus_rw_n_c_o,
  output logic              bus_idle_c_o,
  output logic              rdy_o,
  output logic              active_o
);
  import nes_bus_pkg::*;

  localparam int unsigned IDX_W  = $clog2(DMA_LEN);
  localparam int unsigned PAGE_W = ADDR_W - IDX_W;
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DMA_LEN - 1);
  localparam logic [ADDR_W-1:0] OAM_ADDR = ADDR_W'(PPU_BASE) | ADDR_W'(OAM_DATA_REG);

  dma_state_t        state_q;
  logic [PAGE_W-1:0] page_q;
  logic [IDX_W-1:0]  idx_q;
  logic [DATA_W-1:0] buf_q;
  logic              rdy_q;
  logic              active_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= DMA_IDLE;
      page_q   <= '0;
      idx_q    <= '0;
      buf_q    <= '0;
      rdy_q    <= 1'b1;
      active_q <= 1'b0;
    end else if (ce_i) begin
      case (state_q)
        DMA_IDLE: begin
          if (!cpu_rw_n_i && cpu_addr_i == DMA_REG) begin
            page_q   <= PAGE_W'(cpu_data_i);
            idx_q    <= '0;
            state_q  <= DMA_HALT;
            rdy_q    <= 1'b0;
            active_q <= 1'b1;
          end
        end
        // Odd parity at the halt cycle costs one extra cycle to land reads on get cycles
        DMA_HALT:  state_q <= parity_i ? DMA_ALIGN : DMA_RD;
        DMA_ALIGN: state_q <= DMA_RD;
        DMA_RD: begin
          buf_q   <= rdata_i;
          state_q <= DMA_WR;
        end
        DMA_WR: begin
          if (idx_q == IDX_LAST) begin
            state_q  <= DMA_IDLE;
            rdy_q    <= 1'b1;
            active_q <= 1'b0;
          end else begin
            idx_q   <= idx_q + IDX_W'(1);
            state_q <= DMA_RD;
          end
        end
        default: state_q <= DMA_IDLE;
      endcase
    end
  end

  // Bus override: CPU passes through only while idle
  always_comb begin
    bus_addr_c_o = cpu_addr_i;
    bus_data_c_o = cpu_data_i;
    bus_rw_n_c_o = cpu_rw_n_i;
    bus_idle_c_o = 1'b0;
    case (state_q)
      DMA_HALT, DMA_ALIGN: begin
        bus_addr_c_o = {page_q, idx_q};
        bus_data_c_o = buf_q;
        bus_rw_n_c_o = 1'b1;
        bus_idle_c_o = 1'b1;
      end
      DMA_RD: begin
        bus_addr_c_o = {page_q, idx_q};
        bus_data_c_o = buf_q;
        bus_rw_n_c_o = 1'b1;
      end
      DMA_WR: begin
        bus_addr_c_o = OAM_ADDR;
        bus_data_c_o = buf_q;
        bus_rw_n_c_o = 1'b0;
      end
      default: ;
    endcase
  end

  assign rdy_o    = rdy_q;
  assign active_o = active_q;

endmodule

// File: rtl/cpu_bus_ctrl.sv
// CPU-side bus controller: mirrored region decode, read mux, open-bus latch, OAM DMA.
module cpu_bus_ctrl #(
  parameter int unsigned           ADDR_W       = 16,
  parameter int unsigned           DATA_W       = 8,
  parameter int unsigned           RAM_AW       = 11,
  parameter int unsigned           PPU_REG_AW   = 3,
  parameter int unsigned           DMA_LEN      = 256,
  parameter logic [ADDR_W-1:0]     DMA_REG      = ADDR_W'(16'h4014),
  parameter logic [PPU_REG_AW-1:0] OAM_DATA_REG = PPU_REG_AW'(4)
) (
  input logic           CLK,
  input logic           RESET,
  cpu_bus_ctrl_if.slave bus
);
  import nes_bus_pkg::*;

  logic              parity_q, parity_d;
  logic [DATA_W-1:0] ob_q, ob_d;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_rw_n;
  logic              bus_idle;
  logic [DATA_W-1:0] rdata;
  logic              dma_hit;
  logic              en;
  bus_region_t       region;

  oam_dma_engine #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .PPU_REG_AW  (PPU_REG_AW),
    .DMA_LEN     (DMA_LEN),
    .DMA_REG     (DMA_REG),
    .OAM_DATA_REG(OAM_DATA_REG)
  ) u_dma (
    .clk         (CLK),
    .rst         (RESET),
    .ce_i        (bus.CPU_CE),
    .parity_i    (parity_q),
    .cpu_addr_i  (bus.CPU_ADDR),
    .cpu_data_i  (bus.CPU_DATA_OUT),
    .cpu_rw_n_i  (bus.CPU_RW_n),
    .rdata_i     (rdata),
    .bus_addr_c_o(bus_addr),
    .bus_data_c_o(bus_wdata),
    .bus_rw_n_c_o(bus_rw_n),
    .bus_idle_c_o(bus_idle),
    .rdy_o       (bus.CPU_RDY),
    .active_o    (bus.DMA_ACTIVE)
  );

  // Region decode on the effective bus address
  always_comb begin
    region = REG_NONE;
    if (!bus_idle) begin
      if (bus_addr < ADDR_W'(PPU_BASE))      region = REG_RAM;
      else if (bus_addr < ADDR_W'(IO_BASE))  region = REG_PPU;
      else if (bus_addr < ADDR_W'(PRG_BASE)) region = REG_IO;
      else                                   region = REG_PRG;
    end
  end

  assign dma_hit = (bus_addr == DMA_REG);
  assign en      = bus.CPU_CE & ~RESET;

  assign bus.RAM_rden = en & (region == REG_RAM) &  bus_rw_n;
  assign bus.RAM_wren = en & (region == REG_RAM) & ~bus_rw_n;
  assign bus.PPU_rden = en & (region == REG_PPU) &  bus_rw_n;
  assign bus.PPU_wren = en & (region == REG_PPU) & ~bus_rw_n;
  assign bus.IO_rden  = en & (region == REG_IO) & ~dma_hit &  bus_rw_n;
  assign bus.IO_wren  = en & (region == REG_IO) & ~dma_hit & ~bus_rw_n;
  assign bus.PRG_rden = en & (region == REG_PRG) &  bus_rw_n;
  assign bus.PRG_wren = en & (region == REG_PRG) & ~bus_rw_n;

  assign bus.RAM_ADDR = bus_addr[RAM_AW-1:0];
  assign bus.PPU_REG  = bus_addr[PPU_REG_AW-1:0];
  assign bus.BUS_ADDR = bus_addr;
  assign bus.BUS_DATA = bus_wdata;
  assign bus.BUS_RW_n = bus_rw_n;

  // Undriven reads (invalid IO, $4014, idle DMA cycles) return the open-bus value
  always_comb begin
    rdata = ob_q;
    case (region)
      REG_RAM: rdata = bus.RAM_DATA;
      REG_PPU: rdata = bus.PPU_DATA;
      REG_IO:  if (bus.IO_DATA_VALID && !dma_hit) rdata = bus.IO_DATA;
      REG_PRG: rdata = bus.PRG_DATA;
      default: ;
    endcase
  end

  assign bus.CPU_DATA_IN = RESET ? '0 : rdata;

  always_comb begin
    parity_d = parity_q;
    ob_d     = ob_q;
    if (bus.CPU_CE) begin
      parity_d = ~parity_q;
      ob_d     = bus_rw_n ? rdata : bus_wdata;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      parity_q <= 1'b0;
      ob_q     <= '0;
    end else begin
      parity_q <= parity_d;
      ob_q     <= ob_d;
    end
  end

endmodule

// File: tb/tb_cpu_bus_ctrl.sv
// Randomized self-checking bench for cpu_bus_ctrl against a behavioural bus model.
module tb_cpu_bus_ctrl;

  localparam logic [7:0] S_RAM_RD = 8'h80, S_RAM_WR = 8'h40;
  localparam logic [7:0] S_PPU_RD = 8'h20, S_PPU_WR = 8'h10;
  localparam logic [7:0] S_IO_RD  = 8'h08, S_IO_WR  = 8'h04;
  localparam logic [7:0] S_PRG_RD = 8'h02, S_PRG_WR = 8'h01;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cpu_bus_ctrl_if bus ();
  cpu_bus_ctrl dut (.CLK(clk), .RESET(rst), .bus(bus));

  // Slave RAM, written only through the DUT strobes
  logic [7:0] ram [2048];
  assign bus.RAM_DATA = ram[bus.RAM_ADDR];
  always @(posedge clk) if (bus.RAM_wren) ram[bus.RAM_ADDR] <= bus.BUS_DATA;

  logic [7:0] strb;
  assign strb = {bus.RAM_rden, bus.RAM_wren, bus.PPU_rden, bus.PPU_wren,
                 bus.IO_rden, bus.IO_wren, bus.PRG_rden, bus.PRG_wren};

  // Reference model state
  logic [7:0] ram_ref [2048];
  logic [7:0] ob_ref;
  logic       par_ref;
  logic       no_io_valid;
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic apply(input logic ce, input logic [15:0] a, input logic [7:0] d, input logic rw);
    @(negedge clk);
    bus.CPU_CE        = ce;
    bus.CPU_ADDR      = a;
    bus.CPU_DATA_OUT  = d;
    bus.CPU_RW_n      = rw;
    bus.PPU_DATA      = 8'($urandom);
    bus.IO_DATA       = 8'($urandom);
    bus.IO_DATA_VALID = no_io_valid ? 1'b0 : 1'($urandom);
    bus.PRG_DATA      = 8'($urandom);
    #1;
  endtask

  task automatic junk(input logic ce);
    apply(ce, 16'($urandom), 8'($urandom), 1'($urandom));
  endtask

  // One CPU bus cycle outside DMA, optionally followed by a CE=0 gap
  task automatic cpu_op(input logic [15:0] a, input logic [7:0] d, input logic rw);
    logic [7:0] es;
    logic [7:0] er;
    apply(1'b1, a, d, rw);
    es = 8'h00;
    er = ob_ref;
    if (a < 16'h2000) begin
      es = rw ? S_RAM_RD : S_RAM_WR;
      er = ram_ref[a[10:0]];
      chk("ram_addr", 32'(bus.RAM_ADDR), 32'(a[10:0]));
    end else if (a < 16'h4000) begin
      es = rw ? S_PPU_RD : S_PPU_WR;
      er = bus.PPU_DATA;
      chk("ppu_reg", 32'(bus.PPU_REG), 32'(a[2:0]));
    end else if (a < 16'h4020) begin
      if (a != 16'h4014) begin
        es = rw ? S_IO_RD : S_IO_WR;
        if (bus.IO_DATA_VALID) er = bus.IO_DATA;
      end
    end else begin
      es = rw ? S_PRG_RD : S_PRG_WR;
      er = bus.PRG_DATA;
    end
    chk("strobes", 32'(strb), 32'(es));
    chk("rdy", 32'(bus.CPU_RDY), 32'd1);
    if (rw) chk("rdata", 32'(bus.CPU_DATA_IN), 32'(er));
    else if (a < 16'h2000) ram_ref[a[10:0]] = d;
    ob_ref  = rw ? er : d;
    par_ref = ~par_ref;
    if ($urandom_range(0, 3) == 0) begin
      junk(1'b0);
      chk("ce0_strobes", 32'(strb), 32'd0);
    end
  endtask

  task automatic do_reset_mid();
    @(negedge clk);
    rst = 1'b1;
    bus.CPU_CE = 1'b1;
    #1;
    chk("rst_rdy", 32'(bus.CPU_RDY), 32'd1);
    chk("rst_active", 32'(bus.DMA_ACTIVE), 32'd0);
    chk("rst_strobes", 32'(strb), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.CPU_CE = 1'b0;
    ob_ref  = 8'h00;
    par_ref = 1'b0;
  endtask

  // Trigger a DMA of a RAM page and follow it cycle by cycle
  task automatic run_dma(input logic [7:0] page, input int abort_after);
    logic        align;
    logic        done;
    logic [15:0] src;
    int j, t, writes;
    align  = (par_ref == 1'b0);
    done   = 1'b0;
    j      = 0;
    writes = 0;
    cpu_op(16'h4014, page, 1'b0);
    for (int it = 0; it < 700; it++) begin
      junk(1'b0);
      chk("dma_ce0_strobes", 32'(strb), 32'd0);
      if (bus.CPU_RDY) begin
        done = 1'b1;
        break;
      end
      chk("dma_active", 32'(bus.DMA_ACTIVE), 32'd1);
      junk(1'b1);
      chk("dma_rdy", 32'(bus.CPU_RDY), 32'd0);
      t = j - (align ? 2 : 1);
      if (align && j == 1) begin
        chk("align_idle", 32'(strb), 32'd0);
      end else if (j >= 1) begin
        src = {page, 8'(t / 2)};
        if (t % 2 == 0) begin
          chk("dma_rd_addr", 32'(bus.BUS_ADDR), 32'(src));
          chk("dma_rd_strb", 32'(strb), 32'(S_RAM_RD));
        end else begin
          chk("dma_wr_addr", 32'(bus.BUS_ADDR), 32'h2004);
          chk("dma_wr_strb", 32'(strb), 32'(S_PPU_WR));
          chk("dma_wr_reg", 32'(bus.PPU_REG), 32'd4);
          chk("dma_wr_data", 32'(bus.BUS_DATA), 32'(ram_ref[src[10:0]]));
          writes++;
        end
        ob_ref = ram_ref[src[10:0]];
      end
      par_ref = ~par_ref;
      j++;
      if (writes == abort_after) begin
        do_reset_mid();
        return;
      end
    end
    chk("dma_done", 32'(done), 32'd1);
    chk("stall_len", 32'(j), align ? 32'd514 : 32'd513);
    chk("dma_writes", 32'(writes), 32'd256);
    chk("dma_active_end", 32'(bus.DMA_ACTIVE), 32'd0);
  endtask

  task automatic random_ops(input int n);
    logic [15:0] a;
    logic        rw;
    for (int i = 0; i < n; i++) begin
      a  = 16'($urandom);
      rw = 1'($urandom);
      if (!rw && a == 16'h4014) a = 16'h4015;
      cpu_op(a, 8'($urandom), rw);
    end
  endtask

  initial begin
    no_io_valid = 1'b0;
    ob_ref      = 8'h00;
    par_ref     = 1'b0;
    rst         = 1'b1;
    bus.CPU_CE  = 1'b0;
    repeat (2) @(posedge clk);
    apply(1'b1, 16'h0000, 8'h00, 1'b1);
    chk("reset_rdy", 32'(bus.CPU_RDY), 32'd1);
    chk("reset_active", 32'(bus.DMA_ACTIVE), 32'd0);
    chk("reset_strobes", 32'(strb), 32'd0);
    chk("reset_rdata", 32'(bus.CPU_DATA_IN), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.CPU_CE = 1'b0;

    cpu_op(16'h0801, 8'hA5, 1'b0);
    cpu_op(16'h1801, 8'h00, 1'b1);
    cpu_op(16'h3FFA, 8'h00, 1'b1);
    cpu_op(16'h0000, 8'h5C, 1'b0);
    no_io_valid = 1'b1;
    cpu_op(16'h4018, 8'h00, 1'b1);
    no_io_valid = 1'b0;
    cpu_op(16'h4014, 8'h00, 1'b1);

    // Fill all of RAM through random mirrors; page $02 holds its own index
    for (int i = 0; i < 2048; i++) begin
      cpu_op(16'(i + 2048 * $urandom_range(0, 3)),
             ((i >> 8) == 2) ? 8'(i) : 8'($urandom), 1'b0);
    end
    random_ops(300);

    if (par_ref != 1'b0) cpu_op(16'h0002, 8'h00, 1'b1);
    run_dma(8'h02, -1);
    if (par_ref != 1'b1) cpu_op(16'h0003, 8'h00, 1'b1);
    run_dma(8'h0A, -1);
    random_ops(200);

    run_dma(8'h02, 100);
    run_dma(8'h05, -1);
    random_ops(200);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
